// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IFU = 1'b0,
      REQ_LSU = 1'b1
   } req_id_t;

   // Tie-break history after reset points at the IFU, so the LSU wins the first tie.
   localparam req_id_t RESET_LAST_GRANT = REQ_IFU;

   // Memory is addressed in 8-byte words; these low address bits are forced to zero.
   localparam int unsigned ALIGN_BITS     = 3;
   localparam logic [63:0] ALIGN_LSB_MASK = 64'((1 << ALIGN_BITS) - 1);

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to whoever did not win last time.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   output logic       grant_valid,
   output req_id_t    grant_id
);

   // Select winner; bit 0 is the IFU, bit 1 the LSU.
   always_comb begin
      grant_valid = |req;
      grant_id    = REQ_IFU;
      case (req)
         2'b01:   grant_id = REQ_IFU;
         2'b10:   grant_id = REQ_LSU;
         2'b11:   grant_id = (last == REQ_IFU) ? REQ_LSU : REQ_IFU;
         default: grant_id = REQ_IFU;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between IFU and LSU, one transaction in flight.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned MASK_W = DATA_W / 8;
   localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(ALIGN_LSB_MASK);

   state_t              state;
   req_id_t             owner;
   req_id_t             last_grant;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;

   logic                grant_valid;
   req_id_t             grant_id;
   logic                accept;
   logic                resp_fire;

   rr_pick2 u_pick (
      .req         ({lsu_req_valid, ifu_req_valid}),
      .last        (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Handshake qualifiers; reset masks both so nothing is accepted or routed in the reset cycle.
   assign accept    = !reset && (state == IDLE) && grant_valid;
   assign resp_fire = !reset && (state == WAIT) && mem_resp_valid;

   assign ifu_req_ready  = accept && (grant_id == REQ_IFU);
   assign lsu_req_ready  = accept && (grant_id == REQ_LSU);
   assign ifu_resp_valid = resp_fire && (owner == REQ_IFU);
   assign lsu_resp_valid = resp_fire && (owner == REQ_LSU);
   assign ifu_rdata      = mem_rdata;
   assign lsu_rdata      = mem_rdata;

   assign mem_req_valid = (state == REQ);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

   // Transaction FSM plus request latch; latched fields hold until the memory handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= REQ_IFU;
         last_grant <= RESET_LAST_GRANT;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner      <= grant_id;
                  last_grant <= grant_id;
                  state      <= REQ;
                  if (grant_id == REQ_LSU) begin
                     addr_q  <= lsu_addr & ADDR_ALIGN;
                     wen_q   <= lsu_wen;
                     wdata_q <= lsu_wdata;
                     wmask_q <= lsu_wmask;
                  end else begin
                     addr_q  <= ifu_addr & ADDR_ALIGN;
                     wen_q   <= 1'b0;
                     wdata_q <= '0;
                     wmask_q <= '0;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) state <= WAIT;
            end
            WAIT: begin
               if (mem_resp_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [63:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clock          (clock),
      .reset          (reset),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_rdata      (ifu_rdata),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_addr       (lsu_addr),
      .lsu_wen        (lsu_wen),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_rdata      (lsu_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Step to 1 time unit after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Runs one transaction starting in the accept cycle (inputs already driven).
   task automatic run_txn(input bit lsu_win, input logic [63:0] e_addr, input bit e_wen,
                          input logic [63:0] e_wdata, input logic [7:0] e_mask,
                          input logic [63:0] rd, input int stall);
      #2;
      check("accept_ifu_ready", 64'(ifu_req_ready), 64'(!lsu_win));
      check("accept_lsu_ready", 64'(lsu_req_ready), 64'(lsu_win));
      for (int i = 0; i <= stall; i++) begin
         cyc();
         mem_req_ready = (i == stall);
         #2;
         check("req_valid", 64'(mem_req_valid), 64'd1);
         check("req_addr", mem_addr, e_addr);
         check("req_wen", 64'(mem_wen), 64'(e_wen));
         check("req_wdata", mem_wdata, e_wdata);
         check("req_wmask", 64'(mem_wmask), 64'(e_mask));
         check("req_ready_blocked", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      end
      cyc();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = rd;
      #2;
      check("resp_ifu_valid", 64'(ifu_resp_valid), 64'(!lsu_win));
      check("resp_lsu_valid", 64'(lsu_resp_valid), 64'(lsu_win));
      check("resp_rdata", lsu_win ? lsu_rdata : ifu_rdata, rd);
      check("resp_ready_blocked", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      check("resp_no_req", 64'(mem_req_valid), 64'd0);
      cyc();
      mem_resp_valid = 1'b0;
      #2;
      check("post_resp_quiet", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      check("post_resp_no_req", 64'(mem_req_valid), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = '0;
      lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

      // Reset state: no readiness even with requests pending.
      cyc(); cyc();
      #2;
      check("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      check("rst_mem_req", 64'(mem_req_valid), 64'd0);
      check("rst_addr", mem_addr, 64'd0);
      check("rst_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);

      // IFU read only, aligned address, 2-cycle latency.
      cyc();
      reset = 1'b0; lsu_req_valid = 1'b0;
      ifu_addr = 64'h8000_0004;
      run_txn(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'hDEAD_BEEF_0000_0013, 0);

      // LSU write, then IFU read sees wen/wmask cleared.
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0010; lsu_wen = 1'b1;
      lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'h0F;
      run_txn(1'b1, 64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 0);
      lsu_req_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 64'h8000_001F;
      run_txn(1'b0, 64'h8000_0018, 1'b0, 64'd0, 8'h00, 64'h0000_0000_1234_5678, 0);

      // Back-to-back ties: last winner was IFU, so LSU, IFU, LSU.
      ifu_addr = 64'h204; lsu_req_valid = 1'b1;
      lsu_addr = 64'h10B; lsu_wen = 1'b0; lsu_wdata = 64'hAAAA; lsu_wmask = 8'hFF;
      run_txn(1'b1, 64'h108, 1'b0, 64'hAAAA, 8'hFF, 64'h1, 0);
      run_txn(1'b0, 64'h200, 1'b0, 64'd0, 8'h00, 64'h2, 0);
      run_txn(1'b1, 64'h108, 1'b0, 64'hAAAA, 8'hFF, 64'h3, 0);

      // Memory backpressure for 4 cycles on an LSU write.
      ifu_req_valid = 1'b0;
      lsu_addr = 64'h8000_0047; lsu_wen = 1'b1; lsu_wdata = 64'hCAFE_F00D_0BAD_BEEF; lsu_wmask = 8'hF0;
      run_txn(1'b1, 64'h8000_0040, 1'b1, 64'hCAFE_F00D_0BAD_BEEF, 8'hF0, 64'h0, 4);

      // Reset while in WAIT; the late response is dropped.
      lsu_wen = 1'b0; lsu_addr = 64'h300;
      #2;
      check("rw_accept", 64'(lsu_req_ready), 64'd1);
      cyc();
      lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0; reset = 1'b1;
      #2;
      check("rw_rst_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      cyc();
      reset = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h5555;
      #2;
      check("rw_late_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      check("rw_idle", 64'(mem_req_valid), 64'd0);
      cyc();
      mem_resp_valid = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 64'h400;
      lsu_req_valid = 1'b1; lsu_addr = 64'h500; lsu_wmask = 8'h01; lsu_wdata = 64'h77;
      run_txn(1'b1, 64'h500, 1'b0, 64'h77, 8'h01, 64'h9, 0);

      // Spurious response in IDLE is ignored.
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_rdata = 64'hBAD;
      #2;
      check("spur_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      cyc();
      mem_resp_valid = 1'b0;
      #2;
      check("spur_state", 64'(mem_req_valid), 64'd0);
      cyc();
      ifu_req_valid = 1'b1; ifu_addr = 64'h608;
      run_txn(1'b0, 64'h608, 1'b0, 64'd0, 8'h00, 64'hF00D, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 64-bit physical-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) in the multi-cycle NPC. It accepts one request at a time, forwards it to memory with a valid/ready handshake, and routes the response back to the owning requester. Only one transaction is ever outstanding. Round-robin grant prevents either side from starving.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width; the mask is `DATA_W/8` bits.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ifu_req_valid` in 1: IFU read request.
- `ifu_req_ready` out 1: IFU request accepted this cycle.
- `ifu_addr` in ADDR_W: IFU byte address.
- `ifu_resp_valid` out 1: one-cycle pulse; `ifu_rdata` is valid.
- `ifu_rdata` out DATA_W: returned 8-byte-aligned word.
- `lsu_req_valid` in 1: LSU request.
- `lsu_req_ready` out 1: LSU request accepted this cycle.
- `lsu_addr` in ADDR_W: LSU byte address.
- `lsu_wen` in 1: 1 = write, 0 = read.
- `lsu_wdata` in DATA_W: write data.
- `lsu_wmask` in DATA_W/8: byte enables.
- `lsu_resp_valid` out 1: one-cycle pulse; read data valid, or write complete.
- `lsu_rdata` out DATA_W: returned word.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out ADDR_W: `{addr[ADDR_W-1:3], 3'b0}`.
- `mem_wen` out 1: write enable.
- `mem_wdata` out DATA_W: write data.
- `mem_wmask` out DATA_W/8: byte enables.
- `mem_resp_valid` in 1: memory response.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE, request selection**
  - If exactly one `*_req_valid` is high, that requester wins.
  - If both are high, the requester that did not win the last grant wins. `last_grant` resets to IFU, so the LSU wins the first tie.
- **IDLE, acceptance**
  - The winner's `*_req_ready` is driven high combinationally in the same cycle.
  - Its addr/wen/wdata/wmask and `owner` are latched. State goes to REQ, and `last_grant` is set to the winner.
  - IFU requests latch `wen=0` and `wmask=0`.
- **REQ**
  - `mem_req_valid=1`, driven from the latched registers, which are stable until handshake.
  - On `mem_req_ready`, state goes to WAIT.
- **WAIT**
  - On `mem_resp_valid`, pulse `owner`'s `*_resp_valid` and drive `*_rdata = mem_rdata` combinationally. State goes to IDLE.
- Both `*_req_ready` are 0 outside IDLE.
- The non-owner `*_resp_valid` is always 0.
- `ifu_rdata` and `lsu_rdata` may both mirror `mem_rdata`; only the `resp_valid` signals are qualified.
- `mem_resp_valid` in IDLE or REQ is a protocol error: it is ignored and no response is routed.
- Address alignment is the arbiter's job. Sub-word selection is the requester's job, e.g. IFU uses `pc[2]`.

## Timing
- Reset: state=IDLE, `last_grant`=IFU, `mem_req_valid`=0, both `*_req_ready`=0 in the reset cycle, both `*_resp_valid`=0. Latched registers are cleared to 0.
- Reset mid-transaction aborts it. Any later `mem_resp_valid` arrives in IDLE and is dropped.
- Minimum latency with memory always ready and a 1-cycle response:
  - accept at cycle 0;
  - `mem_req_valid` at cycle 1 (handshake);
  - `mem_resp_valid` and `*_resp_valid` at cycle 2.
- Back-to-back: the cycle after a response is IDLE, so the next accept happens there. Throughput is one transaction per 3 cycles minimum.
- A requester may drop `req_valid` before acceptance without side effects.
- Requester inputs are sampled only on the accept cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - `state_t` (IDLE, REQ, WAIT);
  - `req_id_t` (REQ_IFU, REQ_LSU);
  - `RESET_LAST_GRANT = REQ_IFU`;
  - the alignment mask constant.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker. Inputs are `req[1:0]` and `last`; outputs are `grant_valid` and `grant_id`.
- Top level holds the FSM, latch registers and response routing.

## Test plan
- **IFU read only:** `ifu_req_valid=1`, `ifu_addr=0x8000_0004`, memory ready and responding `0xDEAD_BEEF_0000_0013` one cycle later.
  - `mem_addr=0x8000_0000`, `mem_wen=0`.
  - `ifu_resp_valid` pulses at cycle 2 with that data; `lsu_resp_valid` stays 0.
- **Simultaneous first request:** IFU and LSU both valid after reset.
  - LSU granted first; IFU granted on the next IDLE; alternation continues while both are held valid.
- **LSU write:** `addr=0x8000_0010`, `wdata=0x1122_3344_5566_7788`, `wmask=0x0F`.
  - The memory side sees exactly these values with `mem_wen=1`.
  - `lsu_resp_valid` pulses once on `mem_resp_valid`.
- **Memory backpressure:** hold `mem_req_ready=0` for 4 cycles.
  - `mem_req_valid` and all request fields stay stable.
  - Both `*_req_ready` stay 0 until the response completes.
- **Reset in WAIT:** assert `reset` for 1 cycle, then raise `mem_resp_valid`.
  - No `*_resp_valid` pulse; state is IDLE; the next simultaneous request goes to LSU.
- **Spurious response:** `mem_resp_valid` in IDLE.
  - Ignored, no output pulse, state unchanged.
